// File: rtl/lfsr_sync_checker.sv
// Self-synchronising receive checker for a 32-bit XOR LFSR word stream.
// Define LFSR_CHK_BIT_ERR_EN to add the bit_err_count output (popcount of mismatching bits).
module lfsr_sync_checker #(
  parameter logic [31:0] POLY       = 32'h80200003,
  parameter int          LOCK_COUNT = 4,
  parameter int          LOSS_COUNT = 8,
  parameter int          CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             err_clear,
  input  logic             dv_in,
  input  logic [31:0]      datain,
  output logic             locked,
  output logic             error,
  output logic [CNT_W-1:0] err_count,
`ifdef LFSR_CHK_BIT_ERR_EN
  output logic [31:0]      bit_err_count,
`endif
  output logic             lock_lost
);

  typedef enum logic [1:0] {
    S_HUNT   = 2'd0,
    S_VERIFY = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  state_t           r_state;
  logic [31:0]      r_expected;
  logic [3:0]       r_match_cnt;
  logic [7:0]       r_miss_cnt;
  logic             r_locked;
  logic             r_error;
  logic [CNT_W-1:0] r_err_count;
  logic             r_lock_lost;

  logic        w_match;
  logic        w_zero;
  logic        w_miss_event;
  logic [31:0] w_next_data;
  logic [31:0] w_next_exp;

  function automatic logic [31:0] f_next(input logic [31:0] w);
    return {w[30:0], ^(w & POLY)};
  endfunction

  assign w_match      = (datain == r_expected);
  assign w_zero       = (datain == 32'd0);
  assign w_next_data  = f_next(datain);
  assign w_next_exp   = f_next(r_expected);
  assign w_miss_event = dv_in && (r_state == S_LOCKED) && !w_match;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_HUNT;
      r_expected  <= 32'd0;
      r_match_cnt <= 4'd0;
      r_miss_cnt  <= 8'd0;
      r_locked    <= 1'b0;
      r_error     <= 1'b0;
      r_err_count <= '0;
      r_lock_lost <= 1'b0;
    end else begin
      r_lock_lost <= 1'b0;
      if (dv_in) begin
        case (r_state)
          S_HUNT: begin
            // All-zero is the XOR-LFSR lockup word and can never seed a lock.
            if (!w_zero) begin
              r_expected  <= w_next_data;
              r_match_cnt <= 4'd0;
              r_state     <= S_VERIFY;
            end
          end
          S_VERIFY: begin
            r_expected <= w_next_data;
            if (w_match) begin
              if (r_match_cnt == 4'(LOCK_COUNT - 1)) begin
                r_state     <= S_LOCKED;
                r_locked    <= 1'b1;
                r_match_cnt <= 4'd0;
                r_miss_cnt  <= 8'd0;
              end else begin
                r_match_cnt <= r_match_cnt + 4'd1;
              end
            end else begin
              r_match_cnt <= 4'd0;
              if (w_zero) r_state <= S_HUNT;
            end
          end
          S_LOCKED: begin
            // Flywheel: the prediction never reseeds from received data here.
            r_expected <= w_next_exp;
            if (w_match) begin
              r_miss_cnt <= 8'd0;
            end else if (r_miss_cnt == 8'(LOSS_COUNT - 1)) begin
              r_state     <= S_HUNT;
              r_locked    <= 1'b0;
              r_lock_lost <= 1'b1;
              r_miss_cnt  <= 8'd0;
            end else begin
              r_miss_cnt <= r_miss_cnt + 8'd1;
            end
          end
          default: begin
            r_state  <= S_HUNT;
            r_locked <= 1'b0;
          end
        endcase
      end

      // A new error beats a simultaneous clear, so the count restarts at one.
      if (w_miss_event) begin
        r_error <= 1'b1;
        if (err_clear)
          r_err_count <= CNT_W'(1);
        else if (!(&r_err_count))
          r_err_count <= r_err_count + CNT_W'(1);
      end else if (err_clear) begin
        r_error     <= 1'b0;
        r_err_count <= '0;
      end
    end
  end

  assign locked    = r_locked;
  assign error     = r_error;
  assign err_count = r_err_count;
  assign lock_lost = r_lock_lost;

`ifdef LFSR_CHK_BIT_ERR_EN
  logic [31:0] r_bit_err_count;
  logic [31:0] w_diff;
  logic [5:0]  w_popcnt;
  logic [32:0] w_bit_sum;

  assign w_diff = datain ^ r_expected;

  always_comb begin
    w_popcnt = 6'd0;
    for (int i = 0; i < 32; i++) begin
      w_popcnt = w_popcnt + 6'(w_diff[i]);
    end
  end

  assign w_bit_sum = {1'b0, r_bit_err_count} + 33'(w_popcnt);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bit_err_count <= 32'd0;
    end else if (w_miss_event) begin
      if (err_clear)
        r_bit_err_count <= 32'(w_popcnt);
      else
        r_bit_err_count <= w_bit_sum[32] ? 32'hFFFF_FFFF : w_bit_sum[31:0];
    end else if (err_clear) begin
      r_bit_err_count <= 32'd0;
    end
  end

  assign bit_err_count = r_bit_err_count;
`endif

endmodule

// File: tb/tb_lfsr_sync_checker.sv
// Scoreboard bench for lfsr_sync_checker: directed beats queue their expected
// status, a monitor compares one entry per clock just after the edge.
module tb_lfsr_sync_checker;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        err_clear = 1'b0;
  logic        dv_in = 1'b0;
  logic [31:0] datain = 32'd0;
  logic        locked;
  logic        error;
  logic [15:0] err_count;
  logic        lock_lost;
`ifdef LFSR_CHK_BIT_ERR_EN
  logic [31:0] bit_err_count;
`endif

  always #5 clk = ~clk;

  lfsr_sync_checker #(
    .POLY(32'h80200003), .LOCK_COUNT(4), .LOSS_COUNT(8), .CNT_W(16)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .err_clear(err_clear),
    .dv_in(dv_in),
    .datain(datain),
    .locked(locked),
    .error(error),
    .err_count(err_count),
`ifdef LFSR_CHK_BIT_ERR_EN
    .bit_err_count(bit_err_count),
`endif
    .lock_lost(lock_lost)
  );

  typedef struct {
    logic        lk;
    logic        er;
    logic [15:0] cnt;
    logic        ll;
    logic [31:0] bits;
    string       tag;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic        e_lk, e_er, e_ll;
  logic [15:0] e_cnt;
  logic [31:0] e_bits;
  logic [31:0] gen;
  logic [31:0] loss_mask [8];

  function automatic logic [31:0] lfsr_next(input logic [31:0] w);
    return {w[30:0], ^(w & 32'h80200003)};
  endfunction

  task automatic check_now(input exp_t e);
    logic ok;
    ok = (locked === e.lk) && (error === e.er) && (err_count === e.cnt) && (lock_lost === e.ll);
    n_cmp++;
`ifdef LFSR_CHK_BIT_ERR_EN
    ok = ok && (bit_err_count === e.bits);
    if (!ok) $display("FAIL %s: got lk=%0b er=%0b cnt=%0d ll=%0b bits=%0d, want lk=%0b er=%0b cnt=%0d ll=%0b bits=%0d",
                      e.tag, locked, error, err_count, lock_lost, bit_err_count, e.lk, e.er, e.cnt, e.ll, e.bits);
`else
    if (!ok) $display("FAIL %s: got lk=%0b er=%0b cnt=%0d ll=%0b, want lk=%0b er=%0b cnt=%0d ll=%0b",
                      e.tag, locked, error, err_count, lock_lost, e.lk, e.er, e.cnt, e.ll);
`endif
    if (!ok) n_bad++;
  endtask

  function automatic exp_t cur_exp(input string tag);
    exp_t e;
    e.lk = e_lk; e.er = e_er; e.cnt = e_cnt; e.ll = e_ll; e.bits = e_bits; e.tag = tag;
    return e;
  endfunction

  task automatic beat(input logic dv, input logic [31:0] d, input logic clr, input string tag);
    @(negedge clk);
    dv_in = dv;
    datain = d;
    err_clear = clr;
    sb_q.push_back(cur_exp(tag));
  endtask

  task automatic clear_exp();
    e_lk = 1'b0; e_er = 1'b0; e_ll = 1'b0; e_cnt = 16'd0; e_bits = 32'd0;
  endtask

  // Monitor: each queued beat is sampled by the next posedge.
  initial begin
    forever begin
      exp_t m;
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        m = sb_q.pop_front();
        check_now(m);
      end
    end
  end

  initial begin
    loss_mask[0] = 32'hDEADBEEF; loss_mask[1] = 32'h00000001;
    loss_mask[2] = 32'hFFFFFFFF; loss_mask[3] = 32'h80000000;
    loss_mask[4] = 32'h0F0F0F0F; loss_mask[5] = 32'h12345678;
    loss_mask[6] = 32'hA5A5A5A5; loss_mask[7] = 32'h00010000;
    clear_exp();

    repeat (2) @(posedge clk);
    #1;
    check_now(cur_exp("reset_state"));
    @(negedge clk);
    reset_n = 1'b1;

    // Zero words must never leave HUNT.
    repeat (20) beat(1'b1, 32'd0, 1'b0, "zero_hunt");

    // Clean lock from seed 1: locked after the fifth word.
    gen = 32'h00000001;
    for (int i = 0; i < 1000; i++) begin
      e_lk = (i >= 4);
      beat(1'b1, gen, 1'b0, "clean_lock");
      gen = lfsr_next(gen);
    end

    // dv_in gaps: garbage on invalid beats is ignored.
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) begin
        beat(1'b1, gen, 1'b0, "dv_gap");
        gen = lfsr_next(gen);
      end else begin
        beat(1'b0, 32'hFFFFFFFF, 1'b0, "dv_gap");
      end
    end

    e_er = 1'b1; e_cnt = 16'd1; e_bits = 32'd1;
    beat(1'b1, gen ^ 32'h00000020, 1'b0, "bit_flip");
    gen = lfsr_next(gen);
    repeat (3) begin
      beat(1'b1, gen, 1'b0, "sticky_error");
      gen = lfsr_next(gen);
    end

    e_er = 1'b0; e_cnt = 16'd0; e_bits = 32'd0;
    beat(1'b1, gen, 1'b1, "err_clear");
    gen = lfsr_next(gen);

    e_er = 1'b1; e_cnt = 16'd1; e_bits = 32'd2;
    beat(1'b1, gen ^ 32'h00000300, 1'b1, "clear_race");
    gen = lfsr_next(gen);
    for (int i = 0; i < 2; i++) begin
      e_cnt = e_cnt + 16'd1; e_bits = e_bits + 32'd1;
      beat(1'b1, gen ^ 32'h00000001, 1'b0, "err_count_inc");
      gen = lfsr_next(gen);
    end

    // Asynchronous reset between edges, checked before the next posedge.
    @(posedge clk);
    #3;
    dv_in = 1'b0;
    reset_n = 1'b0;
    #1;
    clear_exp();
    check_now(cur_exp("async_reset"));
    @(negedge clk);
    reset_n = 1'b1;

    // VERIFY reseed on a mismatch, no error reported.
    beat(1'b1, 32'h00000001, 1'b0, "verify_seed");
    gen = 32'h12345678;
    beat(1'b1, gen, 1'b0, "verify_reseed");
    gen = lfsr_next(gen);
    for (int i = 0; i < 4; i++) begin
      e_lk = (i == 3);
      beat(1'b1, gen, 1'b0, "lock_after_reseed");
      gen = lfsr_next(gen);
    end
    repeat (2) begin
      beat(1'b1, gen, 1'b0, "locked_clean");
      gen = lfsr_next(gen);
    end

    // Eight consecutive misses force re-hunt.
    for (int k = 0; k < 8; k++) begin
      e_er = 1'b1;
      e_cnt = 16'(k + 1);
      e_bits = e_bits + 32'($countones(loss_mask[k]));
      e_lk = (k < 7);
      e_ll = (k == 7);
      beat(1'b1, gen ^ loss_mask[k], 1'b0, "loss_of_lock");
      gen = lfsr_next(gen);
    end
    e_ll = 1'b0;
    e_lk = 1'b0;
    for (int i = 0; i < 5; i++) begin
      e_lk = (i == 4);
      beat(1'b1, gen, 1'b0, "relock");
      gen = lfsr_next(gen);
    end
    repeat (3) begin
      beat(1'b1, gen, 1'b0, "relocked_clean");
      gen = lfsr_next(gen);
    end

    @(negedge clk);
    dv_in = 1'b0;
    for (int t = 0; t < 20 && sb_q.size() > 0; t++) @(posedge clk);
    #2;
    n_cmp++;
    if (sb_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending entries, want 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
